// File: rtl/imem_boot_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// imem_boot_pkg
// Shared definitions for the instruction-memory boot-load controller:
//   boot_state_t         controller states (IDLE, LOAD, DRAIN, RUN, ERROR)
//   WORD_BYTES           bytes per instruction-memory word
//   WORD_W               width of a program word in bits
//   DEFAULT_DEPTH_WORDS  default instruction-memory depth in words
//   DEFAULT_CNT_W        default word-counter width (2**CNT_W > depth)
// ---------------------------------------------------------------------------
package imem_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    RUN,
    ERROR
  } boot_state_t;

  localparam int unsigned WORD_BYTES          = 4;
  localparam int unsigned WORD_W              = 32;
  localparam int unsigned DEFAULT_DEPTH_WORDS = 1024;
  localparam int unsigned DEFAULT_CNT_W       = 11;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl_if
// Valid/ready stream carrying program words from the external loader
// (debug/UART bridge) into the boot-load controller.
//   ld_valid  loader has a word on ld_data
//   ld_ready  controller accepts the word this cycle
//   ld_data   program word
//   ld_last   marks the final word of the image
// Modports: master = loader side, slave = controller side.
// ---------------------------------------------------------------------------
interface imem_boot_ctrl_if
  import imem_boot_pkg::*;
;
  logic              ld_valid;
  logic              ld_ready;
  logic [WORD_W-1:0] ld_data;
  logic              ld_last;

  modport master (
    output ld_valid,
    output ld_data,
    output ld_last,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    input  ld_last,
    output ld_ready
  );
endinterface

// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
// Boot-load controller for the instruction memory. Streams program words
// from the loader into consecutive memory words while holding the core in
// reset, then hands the memory address port over to the core's PC.
// Ports:
//   clk, rst     system clock, asynchronous active-high reset
//   start        single-cycle pulse that begins a load at word 0
//   ld           loader stream (slave side of imem_boot_ctrl_if)
//   core_pc      core fetch byte address, passed through while running
//   imem_addr    byte address to the instruction memory
//   imem_we      instruction-memory write enable
//   imem_wdata   instruction-memory write data
//   core_rst_n   active-low core reset, 0 holds the core
//   busy         high while loading or draining the final write
//   err          image overflowed the memory
//   load_count   words written in the current or last load
// ---------------------------------------------------------------------------
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int unsigned CNT_W       = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_boot_ctrl_if.slave  ld,
  input  logic [31:0]      core_pc,
  output logic [31:0]      imem_addr,
  output logic             imem_we,
  output logic [31:0]      imem_wdata,
  output logic             core_rst_n,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] load_count
);

  boot_state_t state;
  logic        ld_ready_q;
  logic [31:0] wr_addr;
  logic        accept;

  // ld_ready is a registered copy of "state is LOAD", so it never depends
  // combinationally on ld_valid.
  assign ld.ld_ready = ld_ready_q;
  assign accept      = ld.ld_valid && ld_ready_q;

  // Once running, the core owns the address port with no added latency;
  // otherwise the port shows the registered write address.
  assign imem_addr = (state == RUN) ? core_pc : wr_addr;

  // Single FSM register block. Every output except the address mux is
  // registered here; imem_we is a one-cycle strobe following each accepted
  // beat, so it defaults low and is only raised on acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ld_ready_q <= 1'b0;
      imem_we    <= 1'b0;
      imem_wdata <= '0;
      wr_addr    <= '0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      load_count <= '0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state      <= LOAD;
            load_count <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        LOAD: begin
          // start is deliberately ignored while a load is in progress.
          if (accept) begin
            imem_we    <= 1'b1;
            wr_addr    <= 32'(load_count) * WORD_BYTES;
            imem_wdata <= ld.ld_data;
            load_count <= load_count + 1'b1;
            if (ld.ld_last) begin
              state      <= DRAIN;
              ld_ready_q <= 1'b0;
            end else if (load_count == CNT_W'(DEPTH_WORDS - 1)) begin
              // Memory is full and the image keeps going: the word just
              // accepted is still written, but nothing more is taken.
              state      <= ERROR;
              ld_ready_q <= 1'b0;
              busy       <= 1'b0;
              err        <= 1'b1;
            end
          end
        end
        DRAIN: begin
          state      <= RUN;
          busy       <= 1'b0;
          core_rst_n <= 1'b1;
        end
        RUN: begin
          if (start) begin
            state      <= LOAD;
            core_rst_n <= 1'b0;
            load_count <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ERROR: begin
          if (start) begin
            state      <= LOAD;
            err        <= 1'b0;
            load_count <= '0;
            ld_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          ld_ready_q <= 1'b0;
          core_rst_n <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/imem_boot_ctrl.md
# imem_boot_ctrl

Boot-load controller for the instruction memory. It accepts program words over a valid/ready stream and writes them into consecutive instruction-memory words. It holds the core in reset while loading, then hands the memory address port to the core's PC. It sits between the external loader (debug/UART bridge) and the instruction memory write and address ports.

## Interface
Parameters:
- DEPTH_WORDS, 1024, instruction-memory depth in 32-bit words; a load may not exceed it.
- CNT_W, 11, width of the word counter; must satisfy 2^CNT_W > DEPTH_WORDS.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a load from word 0.
- ld_valid  in  1  loader has a word on ld_data.
- ld_ready  out  1  controller accepts the word this cycle.
- ld_data  in  32  program word.
- ld_last  in  1  qualifies the final word of the image.
- core_pc  in  32  core fetch byte address.
- imem_addr  out  32  byte address to instruction memory.
- imem_we  out  1  instruction-memory write enable.
- imem_wdata  out  32  write data.
- core_rst_n  out  1  core reset, active-low; 0 holds the core.
- busy  out  1  high in LOAD or DRAIN.
- err  out  1  overflow flag.
- load_count  out  CNT_W  words written in the current or last load.

## Operation
- States: IDLE, LOAD, DRAIN, RUN, ERROR.
- Reset values: state=IDLE, core_rst_n=0, ld_ready=0, imem_we=0, imem_wdata=0, imem_addr=0, busy=0, err=0, load_count=0.
- IDLE: core_rst_n=0.
  - start → LOAD, load_count cleared.
- LOAD: ld_ready=1; a beat is accepted when ld_valid && ld_ready.
  - On acceptance: write registered for the next cycle with imem_addr={load_count,2'b00} zero-extended and imem_wdata=ld_data.
  - load_count increments on each acceptance.
  - Accepted beat with ld_last=1 → DRAIN.
  - Accepted beat without ld_last when load_count==DEPTH_WORDS-1 → ERROR. That last word is still written.
  - start is ignored.
- DRAIN: one cycle; the final write is performed; ld_ready=0. Next state is RUN.
- RUN:
  - core_rst_n=1, ld_ready=0, imem_we=0.
  - imem_addr=core_pc, combinational passthrough with no added latency.
  - start → LOAD and core_rst_n=0 from the next cycle.
- ERROR:
  - err=1, core_rst_n=0, ld_ready=0.
  - start → LOAD, clears err and load_count.
- imem_we is only ever high in the cycle after an accepted beat.

## Timing
- Accept-to-write latency: exactly 1 cycle, with imem_we/addr/wdata registered.
- Throughput: one word per cycle while ld_valid is held.
- Handshake:
  - ld_ready depends only on state; it never depends combinationally on ld_valid.
  - ld_data and ld_last are sampled only on an accepted cycle.
- Last beat accepted in cycle N:
  - cycle N+1: DRAIN with the last write.
  - cycle N+2: RUN, core_rst_n=1, imem_addr=core_pc.
- busy=1 exactly in LOAD and DRAIN.
- Reset mid-load: asynchronous return to IDLE.
  - All outputs take their reset values immediately.
  - The partially written image stays in memory; the core stays held.
- Single-word image (first beat has ld_last=1): load_count=1 and the core is released 2 cycles after the beat.
- Overflow boundary: an image of exactly DEPTH_WORDS words with ld_last on the final beat is legal and ends in RUN.

## Structure
- Package imem_boot_pkg holds:
  - the state enum boot_state_t (IDLE, LOAD, DRAIN, RUN, ERROR);
  - the WORD_BYTES=4 constant;
  - the default DEPTH_WORDS.
- Single module: one state register, counter and write-port register set, plus an output mux for imem_addr. No sub-module is needed.

## Test plan
- Reset, then start, then 3 back-to-back beats 0x0062E233, 0x00B67433, 0x00B60933 (last on the third):
  - writes to addresses 0x0, 0x4, 0x8, each one cycle after acceptance;
  - load_count=3; core_rst_n rises 2 cycles after the third beat.
- Loader with gaps (ld_valid toggling every other cycle, 4 words):
  - no spurious imem_we;
  - addresses 0x0–0xC in order.
- With DEPTH_WORDS=4, send 5 beats without last:
  - 4 writes occur, then ERROR with err=1 and ld_ready=0;
  - the fifth beat is never accepted;
  - start clears err.
- In RUN, drive core_pc=0x14: imem_addr=0x14 the same cycle.
  - Then pulse start: core_rst_n=0 next cycle, and a reload begins at address 0x0.
- Assert rst during the 2nd beat of a load:
  - all outputs take reset values asynchronously;
  - after release, state is IDLE and no write occurs.
- start pulsed during LOAD: ignored; load_count is unaffected.
